write_scheduler: RTL and testbench
==================================

WRITE_SCHEDULER -- requirements
Module: write_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: stall cycles tolerated per phase before abort.
REQ-002 Parameter LEN_BITS, default 4: width of the AWLEN inputs.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 AWVALID_M1  in  1  write-address request, master 1 (CPU).
REQ-007 AWVALID_M2  in  1  write-address request, master 2 (DMA).
REQ-008 AWLEN_M1  in  LEN_BITS  burst length-1, master 1.
REQ-009 AWLEN_M2  in  LEN_BITS  burst length-1, master 2.
REQ-010 AWREADY_S  in  1  address ready from the decoded slave.
REQ-011 WVALID_S  in  1  write-data valid on the shared W path.
REQ-012 WREADY_S  in  1  write-data ready from the slave.
REQ-013 WLAST_S  in  1  last-beat flag on the shared W path.
REQ-014 BVALID_S  in  1  write-response valid from the slave.
REQ-015 BREADY_M  in  1  write-response ready from the owning master.
REQ-016 GRANT  out  2  one-hot AW owner ({M2,M1}); 00 = none.
REQ-017 W_SEL  out  2  one-hot W-channel steering select.
REQ-018 B_SEL  out  2  one-hot B-channel steering select.
REQ-019 BUSY  out  1  high whenever state is not IDLE.
REQ-020 LAST_ERR  out  1  sticky flag: WLAST/beat-count mismatch.
REQ-021 TIMEOUT  out  1  one-cycle pulse on transaction abort.

Function
REQ-022 FSM states IDLE, ADDR, DATA, RESP; exactly one write transaction in flight at any time.
REQ-023 IDLE: when any AWVALID_Mx is high, select an owner and go to ADDR next cycle; GRANT is registered, asserted one cycle after request sampled.
REQ-024 Arbitration is round-robin: a priority bit names the preferred master; a lone requester always wins; on simultaneous requests the preferred master wins.
REQ-025 Priority bit resets to M1; on each completed or aborted transaction it points to the master that did NOT own it.
REQ-026 ADDR: GRANT = owner; AW handshake = owner AWVALID_Mx & AWREADY_S; on handshake latch owner AWLEN into beat counter as AWLEN+1 (LEN_BITS+1 wide, no overflow) and go to DATA.
REQ-027 DATA: W_SEL = owner, GRANT = 00; each beat (WVALID_S & WREADY_S) decrements the counter.
REQ-028 DATA exit: on the beat where counter == 1 or WLAST_S == 1, go to RESP next cycle.
REQ-029 If on that exit beat WLAST_S differs from (counter == 1), set LAST_ERR; LAST_ERR clears only on rst.
REQ-030 RESP: B_SEL = owner, W_SEL = 00; on BVALID_S & BREADY_M go to IDLE, update priority.
REQ-031 A stall counter clears on every state change and every W beat; it increments each cycle in ADDR/DATA/RESP otherwise.
REQ-032 When the stall counter reaches TIMEOUT_CYCLES: pulse TIMEOUT for one cycle, go to IDLE, update priority, clear selects.
REQ-033 Owner dropping AWVALID in ADDR keeps the FSM in ADDR (timeout covers it); the other master's requests are ignored until IDLE.
REQ-034 Return to IDLE and new grant are not same-cycle: at least one IDLE cycle between transactions.
REQ-035 GRANT, W_SEL, B_SEL are each one-hot or zero, and at most one of the three is non-zero in any cycle.

Reset
REQ-036 rst high on a clock edge forces IDLE, GRANT=W_SEL=B_SEL=00, BUSY=0, LAST_ERR=0, TIMEOUT=0, counters=0, priority=M1, from any state including mid-burst.
REQ-037 Outputs are undefined-free: every output has a reset value and no latch.

Verification
REQ-038 Single M1 write, AWLEN_M1=3, 4 beats, WLAST on beat 4, BVALID&BREADY -> GRANT=01 in ADDR, W_SEL=01 for 4 beats, B_SEL=01, back to IDLE, LAST_ERR=0.
REQ-039 M1 and M2 request together after reset, then again -> first grant 01, second grant 10 (round-robin alternation).
REQ-040 AWLEN=3, WLAST_S asserted on beat 2 -> RESP entered after beat 2, LAST_ERR=1 and remains 1 until rst.
REQ-041 TIMEOUT_CYCLES=8, slave never asserts BVALID -> TIMEOUT pulses exactly once, 8 cycles after RESP entry, FSM in IDLE next cycle.
REQ-042 rst asserted mid-DATA (beat 2 of 4) -> next cycle all outputs at reset values, priority=M1.
REQ-043 AWLEN=15 (max), 16 beats -> counter does not wrap, RESP entered after beat 16, LAST_ERR=0.

Source files
------------

// File: rtl/write_scheduler_if.sv
// AW/W/B scheduling bundle between two write masters, the shared slave path and the scheduler.
// Scheduler side is the slave modport; the driving environment uses the master modport.
interface write_scheduler_if #(
  parameter int LEN_BITS = 4
);
  logic                AWVALID_M1;
  logic                AWVALID_M2;
  logic [LEN_BITS-1:0] AWLEN_M1;
  logic [LEN_BITS-1:0] AWLEN_M2;
  logic                AWREADY_S;
  logic                WVALID_S;
  logic                WREADY_S;
  logic                WLAST_S;
  logic                BVALID_S;
  logic                BREADY_M;
  logic [1:0]          GRANT;
  logic [1:0]          W_SEL;
  logic [1:0]          B_SEL;
  logic                BUSY;
  logic                LAST_ERR;
  logic                TIMEOUT;

  modport slave (
    input  AWVALID_M1, AWVALID_M2, AWLEN_M1, AWLEN_M2, AWREADY_S,
    input  WVALID_S, WREADY_S, WLAST_S, BVALID_S, BREADY_M,
    output GRANT, W_SEL, B_SEL, BUSY, LAST_ERR, TIMEOUT
  );

  modport master (
    output AWVALID_M1, AWVALID_M2, AWLEN_M1, AWLEN_M2, AWREADY_S,
    output WVALID_S, WREADY_S, WLAST_S, BVALID_S, BREADY_M,
    input  GRANT, W_SEL, B_SEL, BUSY, LAST_ERR, TIMEOUT
  );
endinterface

// File: rtl/write_scheduler.sv
// Round-robin two-master write scheduler, one transaction in flight; GRANT one cycle after request.
// Phases wait on slave/master handshakes indefinitely up to a stall timeout that aborts to IDLE.
module write_scheduler #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_BITS       = 4
) (
  input  logic             clk,
  input  logic             rst,
  write_scheduler_if.slave bus
);

  localparam int STALL_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);
  localparam int CNT_W = LEN_BITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;   // 0 = M1, 1 = M2
  logic               prio_q, prio_d;     // preferred master on a tie
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               last_err_q, last_err_d;

  logic                owner_awvalid;
  logic [LEN_BITS-1:0] owner_awlen;
  logic                w_beat;
  logic                final_beat;
  logic                timed_out;
  logic [1:0]          owner_sel;

  always_comb begin
    owner_awvalid = owner_q ? bus.AWVALID_M2 : bus.AWVALID_M1;
    owner_awlen   = owner_q ? bus.AWLEN_M2   : bus.AWLEN_M1;
    owner_sel     = owner_q ? 2'b10 : 2'b01;
    w_beat        = bus.WVALID_S & bus.WREADY_S;
    final_beat    = (beats_q == CNT_W'(1));
    timed_out     = (state_q != IDLE) && (stall_q == STALL_LIMIT);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    beats_d    = beats_q;
    last_err_d = last_err_q;

    if (timed_out) begin
      state_d = IDLE;
      prio_d  = ~owner_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.AWVALID_M1 | bus.AWVALID_M2) begin
            state_d = ADDR;
            owner_d = (bus.AWVALID_M1 & bus.AWVALID_M2) ? prio_q : bus.AWVALID_M2;
          end
        end
        ADDR: begin
          if (owner_awvalid & bus.AWREADY_S) begin
            beats_d = {1'b0, owner_awlen} + CNT_W'(1);
            state_d = DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            beats_d = beats_q - CNT_W'(1);
            if (final_beat || bus.WLAST_S) begin
              state_d = RESP;
              // WLAST and the length-derived count must agree on the closing beat
              if (bus.WLAST_S != final_beat) begin
                last_err_d = 1'b1;
              end
            end
          end
        end
        RESP: begin
          if (bus.BVALID_S & bus.BREADY_M) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if ((state_d != state_q) || w_beat || (state_q == IDLE)) begin
      stall_d = '0;
    end else if (stall_q != STALL_LIMIT) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      beats_q    <= '0;
      stall_q    <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      beats_q    <= beats_d;
      stall_q    <= stall_d;
      last_err_q <= last_err_d;
    end
  end

  // Selects decode straight from flopped state, so only one of them can be live at a time
  assign bus.GRANT    = (state_q == ADDR) ? owner_sel : 2'b00;
  assign bus.W_SEL    = (state_q == DATA) ? owner_sel : 2'b00;
  assign bus.B_SEL    = (state_q == RESP) ? owner_sel : 2'b00;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.LAST_ERR = last_err_q;
  assign bus.TIMEOUT  = timed_out;

endmodule

// File: tb/tb_write_scheduler.sv
// Directed self-checking bench for write_scheduler with an 8-cycle stall timeout.
module tb_write_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  write_scheduler_if #(.LEN_BITS(4)) bus ();

  write_scheduler #(
    .TIMEOUT_CYCLES(8),
    .LEN_BITS      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {GRANT, W_SEL, B_SEL, BUSY, LAST_ERR, TIMEOUT}
  function automatic logic [8:0] outs();
    return {bus.GRANT, bus.W_SEL, bus.B_SEL, bus.BUSY, bus.LAST_ERR, bus.TIMEOUT};
  endfunction

  task automatic idle_inputs();
    bus.AWVALID_M1 = 1'b0;
    bus.AWVALID_M2 = 1'b0;
    bus.AWLEN_M1   = 4'd0;
    bus.AWLEN_M2   = 4'd0;
    bus.AWREADY_S  = 1'b0;
    bus.WVALID_S   = 1'b0;
    bus.WREADY_S   = 1'b0;
    bus.WLAST_S    = 1'b0;
    bus.BVALID_S   = 1'b0;
    bus.BREADY_M   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic aw_phase(input string tag, input logic m1, input logic m2,
                          input logic [3:0] len1, input logic [3:0] len2,
                          input logic [1:0] exp_own);
    bus.AWVALID_M1 = m1;
    bus.AWVALID_M2 = m2;
    bus.AWLEN_M1   = len1;
    bus.AWLEN_M2   = len2;
    bus.AWREADY_S  = 1'b1;
    step();
    check({tag, ".addr"}, 32'({bus.GRANT, bus.W_SEL, bus.B_SEL, bus.BUSY}),
          32'({exp_own, 4'b0000, 1'b1}));
    step();
    bus.AWVALID_M1 = 1'b0;
    bus.AWVALID_M2 = 1'b0;
    bus.AWREADY_S  = 1'b0;
    check({tag, ".data"}, 32'({bus.GRANT, bus.W_SEL}), 32'({2'b00, exp_own}));
  endtask

  task automatic data_phase(input string tag, input int nbeats, input int wlast_beat,
                            input logic [1:0] own, input logic exp_lerr);
    bus.WVALID_S = 1'b1;
    bus.WREADY_S = 1'b1;
    for (int i = 1; i <= nbeats; i++) begin
      bus.WLAST_S = (i == wlast_beat);
      step();
      if (i < nbeats)
        check($sformatf("%s.beat%0d", tag, i), 32'({bus.W_SEL, bus.B_SEL}), 32'({own, 2'b00}));
    end
    bus.WVALID_S = 1'b0;
    bus.WREADY_S = 1'b0;
    bus.WLAST_S  = 1'b0;
    check({tag, ".resp"}, 32'({bus.W_SEL, bus.B_SEL}), 32'({2'b00, own}));
    check({tag, ".lerr"}, 32'(bus.LAST_ERR), 32'(exp_lerr));
  endtask

  task automatic resp_phase(input string tag, input logic exp_lerr);
    bus.BVALID_S = 1'b1;
    bus.BREADY_M = 1'b1;
    step();
    bus.BVALID_S = 1'b0;
    bus.BREADY_M = 1'b0;
    check({tag, ".idle"}, 32'(outs()), 32'({6'b000000, 1'b0, exp_lerr, 1'b0}));
  endtask

  initial begin
    int pulses;
    idle_inputs();
    rst = 1'b1;
    do_reset();
    check("reset", 32'(outs()), 32'd0);

    // Single M1 write, 4 beats, WLAST on beat 4
    aw_phase("m1", 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
    data_phase("m1", 4, 4, 2'b01, 1'b0);
    resp_phase("m1", 1'b0);

    // Round-robin alternation from reset
    do_reset();
    aw_phase("rr1", 1'b1, 1'b1, 4'd1, 4'd2, 2'b01);
    data_phase("rr1", 2, 2, 2'b01, 1'b0);
    resp_phase("rr1", 1'b0);
    aw_phase("rr2", 1'b1, 1'b1, 4'd1, 4'd2, 2'b10);
    data_phase("rr2", 3, 3, 2'b10, 1'b0);
    resp_phase("rr2", 1'b0);
    aw_phase("rr3", 1'b1, 1'b1, 4'd0, 4'd0, 2'b01);
    data_phase("rr3", 1, 1, 2'b01, 1'b0);
    resp_phase("rr3", 1'b0);

    // Lone M2 wins regardless of priority; maximum length 16 beats
    aw_phase("max", 1'b0, 1'b1, 4'd0, 4'd15, 2'b10);
    data_phase("max", 16, 16, 2'b10, 1'b0);
    resp_phase("max", 1'b0);

    // Early WLAST on beat 2 of 4
    aw_phase("lerr", 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
    data_phase("lerr", 2, 2, 2'b01, 1'b1);
    resp_phase("lerr", 1'b1);

    // Response never arrives: abort after 8 stalled cycles in RESP
    aw_phase("to", 1'b1, 1'b0, 4'd3, 4'd0, 2'b01);
    data_phase("to", 4, 4, 2'b01, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (bus.TIMEOUT) pulses++;
      if (k == 7) check("to.pre", 32'({bus.TIMEOUT, bus.BUSY}), 32'(2'b01));
      if (k == 8) check("to.pulse", 32'({bus.TIMEOUT, bus.BUSY}), 32'(2'b11));
    end
    check("to.count", 32'(pulses), 32'd1);
    check("to.idle", 32'(outs()), 32'({6'b000000, 1'b0, 1'b1, 1'b0}));

    // Priority now favours M2; reset mid-burst must restore M1 preference
    aw_phase("mid", 1'b1, 1'b1, 4'd3, 4'd3, 2'b10);
    bus.WVALID_S = 1'b1;
    bus.WREADY_S = 1'b1;
    step();
    check("mid.beat1", 32'(bus.W_SEL), 32'(2'b10));
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    check("mid.reset", 32'(outs()), 32'd0);
    aw_phase("post", 1'b1, 1'b1, 4'd0, 4'd0, 2'b01);
    data_phase("post", 1, 1, 2'b01, 1'b0);
    resp_phase("post", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
